// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: TAP state encoding, instruction opcodes,
// data-register select codes and the default device ID.
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI,
        ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR,
        ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        SEL_BYPASS, SEL_IDCODE, SEL_LED, SEL_SW
    } dr_sel_e;

    localparam int OPC_IDCODE   = 1;
    localparam int OPC_USER_LED = 2;
    localparam int OPC_USER_SW  = 3;

    localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0001;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine, advanced on rising TCK.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_e state
);

    tap_state_e state_q;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q <= ST_TLR;
        end else begin
            case (state_q)
                ST_TLR:      state_q <= TMS ? ST_TLR      : ST_RTI;
                ST_RTI:      state_q <= TMS ? ST_SEL_DR   : ST_RTI;
                ST_SEL_DR:   state_q <= TMS ? ST_SEL_IR   : ST_CAP_DR;
                ST_CAP_DR:   state_q <= TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
                ST_SHIFT_DR: state_q <= TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
                ST_EXIT1_DR: state_q <= TMS ? ST_UPD_DR   : ST_PAUSE_DR;
                ST_PAUSE_DR: state_q <= TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
                ST_EXIT2_DR: state_q <= TMS ? ST_UPD_DR   : ST_SHIFT_DR;
                ST_UPD_DR:   state_q <= TMS ? ST_SEL_DR   : ST_RTI;
                ST_SEL_IR:   state_q <= TMS ? ST_TLR      : ST_CAP_IR;
                ST_CAP_IR:   state_q <= TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
                ST_SHIFT_IR: state_q <= TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
                ST_EXIT1_IR: state_q <= TMS ? ST_UPD_IR   : ST_PAUSE_IR;
                ST_PAUSE_IR: state_q <= TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
                ST_EXIT2_IR: state_q <= TMS ? ST_UPD_IR   : ST_SHIFT_IR;
                ST_UPD_IR:   state_q <= TMS ? ST_SEL_DR   : ST_RTI;
                default:     state_q <= ST_TLR;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP with BYPASS, USER_LED and USER_SW data registers.
// Define JTAG_TAP_IDCODE_EN to add the 32-bit IDCODE register (reset IR = IDCODE).
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 8,
    parameter logic [31:0] IDCODE_VAL = IDCODE_DEFAULT
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    input  logic [DR_WIDTH-1:0] SW_IN,
    output logic [DR_WIDTH-1:0] LED_DATA,
    output logic                TAP_RESET
);

    localparam logic [IR_WIDTH-1:0] IR_BYPASS = '1;
    localparam logic [IR_WIDTH-1:0] IR_LED    = IR_WIDTH'(OPC_USER_LED);
    localparam logic [IR_WIDTH-1:0] IR_SW     = IR_WIDTH'(OPC_USER_SW);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_BYPASS;
`endif

    tap_state_e state;

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (TMS),
        .state (state)
    );

    assign TAP_RESET = (state == ST_TLR);

    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_act;
    logic                bypass_q, bypass_d;
    logic [DR_WIDTH-1:0] dr_sr_q, dr_sr_d;
    logic [DR_WIDTH-1:0] led_q, led_d;
    logic                tdo_q, tdo_d;
    dr_sel_e             sel;

    // While in Test-Logic-Reset the reset instruction is already in force,
    // so decode sees it on the same edge the state is entered.
    assign ir_act = TAP_RESET ? IR_RESET : ir_q;

    always_comb begin
        sel = SEL_BYPASS;
        case (ir_act)
            IR_LED:    sel = SEL_LED;
            IR_SW:     sel = SEL_SW;
`ifdef JTAG_TAP_IDCODE_EN
            IR_IDCODE: sel = SEL_IDCODE;
`endif
            default:   sel = SEL_BYPASS;
        endcase
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] id_sr_q, id_sr_d;

    always_comb begin
        id_sr_d = id_sr_q;
        if (sel == SEL_IDCODE) begin
            if (state == ST_CAP_DR)        id_sr_d = IDCODE_VAL;
            else if (state == ST_SHIFT_DR) id_sr_d = {TDI, id_sr_q[31:1]};
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) id_sr_q <= '0;
        else      id_sr_q <= id_sr_d;
    end
`else
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VAL;
`endif

    always_comb begin
        ir_sr_d  = ir_sr_q;
        ir_d     = ir_q;
        bypass_d = bypass_q;
        dr_sr_d  = dr_sr_q;
        led_d    = led_q;
        case (state)
            ST_TLR:      ir_d    = IR_RESET;
            ST_CAP_IR:   ir_sr_d = IR_WIDTH'(1);
            ST_SHIFT_IR: ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            ST_UPD_IR:   ir_d    = ir_sr_q;
            ST_CAP_DR: begin
                case (sel)
                    SEL_LED:    dr_sr_d  = led_q;
                    SEL_SW:     dr_sr_d  = SW_IN;
                    SEL_BYPASS: bypass_d = 1'b0;
                    default:    ;
                endcase
            end
            ST_SHIFT_DR: begin
                case (sel)
                    SEL_LED,
                    SEL_SW:     dr_sr_d  = {TDI, dr_sr_q[DR_WIDTH-1:1]};
                    SEL_BYPASS: bypass_d = TDI;
                    default:    ;
                endcase
            end
            ST_UPD_DR:   if (sel == SEL_LED) led_d = dr_sr_q;
            default:     ;
        endcase
    end

    always_comb begin
        tdo_d = 1'b0;
        if (state == ST_SHIFT_IR) begin
            tdo_d = ir_sr_q[0];
        end else if (state == ST_SHIFT_DR) begin
            case (sel)
                SEL_LED,
                SEL_SW:     tdo_d = dr_sr_q[0];
`ifdef JTAG_TAP_IDCODE_EN
                SEL_IDCODE: tdo_d = id_sr_q[0];
`endif
                default:    tdo_d = bypass_q;
            endcase
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_sr_q  <= '0;
            ir_q     <= IR_RESET;
            bypass_q <= 1'b0;
            dr_sr_q  <= '0;
            led_q    <= '0;
        end else begin
            ir_sr_q  <= ir_sr_d;
            ir_q     <= ir_d;
            bypass_q <= bypass_d;
            dr_sr_q  <= dr_sr_d;
            led_q    <= led_d;
        end
    end

    // TDO launches on the falling edge so the host samples it on the next rise.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) tdo_q <= 1'b0;
        else      tdo_q <= tdo_d;
    end

    assign TDO      = tdo_q;
    assign LED_DATA = led_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Randomized scan bench for jtag_tap; expected scan-out is the captured word
// followed by the shifted-in stream, truncated to the number of shifts.
module tb_jtag_tap;

    localparam int IRW = 4;
    localparam int DRW = 8;
    localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef JTAG_TAP_IDCODE_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    localparam logic [IRW-1:0] IR_RST = ID_EN ? 4'h1 : 4'hF;

    logic           TCK = 1'b0;
    logic           TRST = 1'b1;
    logic           TMS = 1'b1;
    logic           TDI = 1'b0;
    logic           TDO;
    logic [DRW-1:0] SW_IN = '0;
    logic [DRW-1:0] LED_DATA;
    logic           TAP_RESET;

    jtag_tap dut (
        .TCK       (TCK),
        .TRST      (TRST),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .SW_IN     (SW_IN),
        .LED_DATA  (LED_DATA),
        .TAP_RESET (TAP_RESET)
    );

    always #5 TCK = ~TCK;

    int n_chk = 0;
    int n_err = 0;

    logic [IRW-1:0] m_ir;
    logic [DRW-1:0] m_led;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One TCK cycle; returns TDO as launched on the following falling edge.
    task automatic step(input logic tms, input logic tdi, output logic tdo);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
        tdo = TDO;
    endtask

    // Scan n bits from Run-Test/Idle back to Run-Test/Idle, optionally
    // pausing after pause_at bits (0 = no pause).
    task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                        input int pause_at, output logic [63:0] dout);
        logic t;
        dout = '0;
        step(1'b1, 1'b0, t);
        if (is_ir) step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        dout[0] = t;
        for (int i = 0; i < n; i++) begin
            bit last, brk;
            last = (i == n - 1);
            brk  = (i == pause_at - 1) && !last;
            step(last || brk, din[i], t);
            if (brk) begin
                step(1'b0, 1'b0, t);
                step(1'b0, 1'b0, t);
                step(1'b1, 1'b0, t);
                step(1'b0, 1'b0, t);
            end
            if (!last) dout[i+1] = t;
        end
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
    endtask

    function automatic int sel_of(input logic [IRW-1:0] op);
        if (op == 4'h2) return 2;
        if (op == 4'h3) return 3;
        if (op == 4'h1 && ID_EN) return 1;
        return 0;
    endfunction

    task automatic ir_scan_chk(input string tag, input int n, input logic [63:0] din, input int pause_at);
        logic [63:0]  got;
        logic [127:0] stream;
        stream = 128'd1 | (128'(din) << IRW);
        scan(1'b1, n, din, pause_at, got);
        chk({tag, "_ir_out"}, 128'(got), stream & ((128'd1 << n) - 1));
        m_ir = IRW'(stream >> n);
    endtask

    task automatic dr_scan_chk(input string tag, input int n, input logic [63:0] din, input int pause_at);
        logic [63:0]  got;
        logic [127:0] stream, cap;
        int           w;
        case (sel_of(m_ir))
            1: begin w = 32;  cap = 128'(IDV);   end
            2: begin w = DRW; cap = 128'(m_led); end
            3: begin w = DRW; cap = 128'(SW_IN); end
            default: begin w = 1; cap = '0; end
        endcase
        stream = cap | (128'(din) << w);
        scan(1'b0, n, din, pause_at, got);
        chk({tag, "_dr_out"}, 128'(got), stream & ((128'd1 << n) - 1));
        if (sel_of(m_ir) == 2) m_led = DRW'(stream >> n);
        chk({tag, "_led"}, 128'(LED_DATA), 128'(m_led));
        chk({tag, "_tdo_idle"}, 128'(TDO), 128'd0);
    endtask

    task automatic tms_reset(input string tag);
        logic t;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, t);
        chk({tag, "_tap_reset"}, 128'(TAP_RESET), 128'd1);
        m_ir = IR_RST;
        step(1'b0, 1'b0, t);
        chk({tag, "_rti"}, 128'(TAP_RESET), 128'd0);
    endtask

    task automatic tms_walk(input int len);
        logic t;
        int   ones;
        ones = 0;
        for (int i = 0; i < len; i++) begin
            logic tms;
            tms = 1'($urandom);
            step(tms, 1'b1, t);
            ones = tms ? ones + 1 : 0;
            if (ones >= 5)     chk("walk_tlr", 128'(TAP_RESET), 128'd1);
            else if (ones == 0) chk("walk_not_tlr", 128'(TAP_RESET), 128'd0);
        end
    endtask

    initial begin
        logic t;
        m_ir  = IR_RST;
        m_led = '0;
        #2;
        chk("rst_tap_reset", 128'(TAP_RESET), 128'd1);
        chk("rst_led", 128'(LED_DATA), 128'd0);
        chk("rst_tdo", 128'(TDO), 128'd0);
        #10 TRST = 1'b0;
        @(negedge TCK);
        #1;

        // Scan straight out of reset: IDCODE if present, else bypass echo.
        step(1'b0, 1'b0, t);
        dr_scan_chk("reset_dr", 40, {$urandom, $urandom}, 0);

        ir_scan_chk("led_ir", IRW, 64'h2, 0);
        dr_scan_chk("led_load", DRW, 64'h99, 0);
        dr_scan_chk("led_rescan", DRW, 64'h3C, 3);

        SW_IN = 8'h55;
        ir_scan_chk("sw_ir", IRW, 64'h3, 0);
        dr_scan_chk("sw_scan", DRW, 64'h0F, 0);

        ir_scan_chk("byp_f_ir", IRW, 64'hF, 0);
        dr_scan_chk("byp_f", 4, 64'b1101, 0);
        ir_scan_chk("byp_7_ir", IRW, 64'h7, 2);
        dr_scan_chk("byp_7", 4, 64'b1101, 2);

        ir_scan_chk("tms_rst_ir", IRW, 64'h3, 0);
        tms_reset("tms_rst");
        chk("tms_rst_led", 128'(LED_DATA), 128'(m_led));
        dr_scan_chk("tms_rst_dr", 36, {$urandom, $urandom}, 0);

        // Asynchronous reset in the middle of a USER_LED shift.
        ir_scan_chk("trst_ir", IRW, 64'h2, 0);
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, t);
        TRST = 1'b1;
        #1;
        chk("trst_tap_reset", 128'(TAP_RESET), 128'd1);
        chk("trst_led", 128'(LED_DATA), 128'd0);
        chk("trst_tdo", 128'(TDO), 128'd0);
        TRST = 1'b0;
        m_led = '0;
        m_ir  = IR_RST;
        step(1'b0, 1'b0, t);
        dr_scan_chk("trst_dr", 12, {$urandom, $urandom}, 0);

        for (int it = 0; it < 40; it++) begin
            logic [IRW-1:0] op;
            int             xir, n, p;
            logic [63:0]    din;
            if (it % 8 == 7) begin
                tms_reset("pre_walk");
                tms_walk(24);
                tms_reset("post_walk");
                chk("walk_led", 128'(LED_DATA), 128'(m_led));
            end
            op    = IRW'($urandom);
            SW_IN = DRW'($urandom);
            xir   = $urandom_range(0, 3);
            din   = {$urandom, $urandom};
            din   = (din & ((64'd1 << xir) - 1)) | (64'(op) << xir);
            ir_scan_chk("rnd", IRW + xir, din, $urandom_range(0, IRW + xir - 1));
            n = $urandom_range(1, 40);
            p = $urandom_range(0, n - 1);
            dr_scan_chk("rnd", n, {$urandom, $urandom}, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
